// File: rtl/bluetooth_cmd_streamer_if.sv
// Command/stream bundle for the Bluetooth ASCII command streamer.
// The master side is the streamer itself: it consumes the command request
// and downstream ready, and produces the byte stream plus status pulses.
interface bluetooth_cmd_streamer_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] input_data;
  logic [3:0]        command_select;
  logic              start;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              busy;
  logic              done;
  logic              error;

  modport master (
    input  input_data,
    input  command_select,
    input  start,
    input  tx_ready,
    output tx_data,
    output tx_valid,
    output busy,
    output done,
    output error
  );

  modport slave (
    output input_data,
    output command_select,
    output start,
    output tx_ready,
    input  tx_data,
    input  tx_valid,
    input  busy,
    input  done,
    input  error
  );
endinterface

// File: rtl/bluetooth_cmd_streamer.sv
// Bluetooth command streamer: turns a command code plus payload into an
// ASCII packet (header, hex payload, optional XOR checksum, CR, LF) and
// streams it one byte per accepted transfer over a valid/ready handshake.
module bluetooth_cmd_streamer #(
  parameter int DATA_W      = 32,
  parameter bit CHECKSUM_EN = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  bluetooth_cmd_streamer_if.master bus
);

  localparam int NIBBLES = DATA_W / 4;
  localparam int CNT_W   = 5;

  localparam logic [3:0] CMD_SEND   = 4'h1;
  localparam logic [3:0] CMD_WRITE  = 4'h2;
  localparam logic [3:0] CMD_READ   = 4'h3;
  localparam logic [3:0] CMD_STATUS = 4'h4;

  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_PAYLOAD,
    S_CKSUM,
    S_CR,
    S_LF,
    S_DONE
  } state_t;

  // Uppercase ASCII for one hex nibble.
  function automatic logic [7:0] hex_char(input logic [3:0] n);
    logic [7:0] c;
    if (n < 4'd10) c = {4'h3, n};
    else           c = 8'h37 + {4'h0, n};
    return c;
  endfunction

  // Header character for a latched (already legal) command.
  function automatic logic [7:0] header_char(input logic [3:0] cmd);
    logic [7:0] c;
    case (cmd)
      CMD_SEND:   c = 8'h53;
      CMD_WRITE:  c = 8'h57;
      CMD_READ:   c = 8'h52;
      CMD_STATUS: c = 8'h51;
      default:    c = 8'h00;
    endcase
    return c;
  endfunction

  state_t            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [3:0]        cmd_q, cmd_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        cksum_q, cksum_d;
  logic              error_q, error_d;

  logic [7:0]        tx_data_c;
  logic              tx_valid_c;
  logic              xfer;
  logic              cmd_legal;
  state_t            after_payload;

  // The state after the payload depends only on whether a checksum is sent.
  assign after_payload = CHECKSUM_EN ? S_CKSUM : S_CR;

  assign cmd_legal = (bus.command_select == CMD_SEND)  ||
                     (bus.command_select == CMD_WRITE) ||
                     (bus.command_select == CMD_READ)  ||
                     (bus.command_select == CMD_STATUS);

  assign xfer = tx_valid_c & bus.tx_ready;

  // Byte presented to the sink, derived purely from state so it is zero and
  // invalid the instant the state machine falls back to IDLE.
  always_comb begin
    tx_valid_c = 1'b0;
    tx_data_c  = 8'h00;
    case (state_q)
      S_HDR: begin
        tx_valid_c = 1'b1;
        tx_data_c  = header_char(cmd_q);
      end
      S_PAYLOAD: begin
        tx_valid_c = 1'b1;
        tx_data_c  = hex_char(data_q[DATA_W-1 -: 4]);
      end
      S_CKSUM: begin
        tx_valid_c = 1'b1;
        tx_data_c  = cnt_q[0] ? hex_char(cksum_q[7:4]) : hex_char(cksum_q[3:0]);
      end
      S_CR: begin
        tx_valid_c = 1'b1;
        tx_data_c  = CHAR_CR;
      end
      S_LF: begin
        tx_valid_c = 1'b1;
        tx_data_c  = CHAR_LF;
      end
      default: begin
        tx_valid_c = 1'b0;
        tx_data_c  = 8'h00;
      end
    endcase
  end

  // Next-state logic: every state only advances on an accepted transfer, so
  // backpressure simply holds the current byte in place.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cmd_d   = cmd_q;
    cnt_d   = cnt_q;
    cksum_d = cksum_q;
    error_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (cmd_legal) begin
            state_d = S_HDR;
            cmd_d   = bus.command_select;
            cksum_d = 8'h00;
            if (bus.command_select == CMD_READ) begin
              // READ sends only the low byte; park it at the top so the
              // payload shifter always emits from the MSB end.
              data_d = DATA_W'(bus.input_data[7:0]) << (DATA_W - 8);
              cnt_d  = CNT_W'(1);
            end else begin
              data_d = bus.input_data;
              cnt_d  = CNT_W'(NIBBLES - 1);
            end
          end else begin
            error_d = 1'b1;
          end
        end
      end

      S_HDR: begin
        if (xfer) begin
          cksum_d = cksum_q ^ tx_data_c;
          if (cmd_q == CMD_STATUS) begin
            state_d = after_payload;
            cnt_d   = CNT_W'(1);
          end else begin
            state_d = S_PAYLOAD;
          end
        end
      end

      S_PAYLOAD: begin
        if (xfer) begin
          cksum_d = cksum_q ^ tx_data_c;
          data_d  = data_q << 4;
          if (cnt_q == '0) begin
            state_d = after_payload;
            cnt_d   = CNT_W'(1);
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end

      S_CKSUM: begin
        if (xfer) begin
          if (cnt_q[0]) cnt_d   = '0;
          else          state_d = S_CR;
        end
      end

      S_CR: begin
        if (xfer) state_d = S_LF;
      end

      S_LF: begin
        if (xfer) state_d = S_DONE;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and latched packet registers; reset wipes everything at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      data_q  <= '0;
      cmd_q   <= '0;
      cnt_q   <= '0;
      cksum_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cmd_q   <= cmd_d;
      cnt_q   <= cnt_d;
      cksum_q <= cksum_d;
      error_q <= error_d;
    end
  end

  assign bus.tx_data  = tx_data_c;
  assign bus.tx_valid = tx_valid_c;
  assign bus.busy     = (state_q != S_IDLE) && (state_q != S_DONE);
  assign bus.done     = (state_q == S_DONE);
  assign bus.error    = error_q;

endmodule

// File: tb/tb_bluetooth_cmd_streamer.sv
// Scoreboard bench for bluetooth_cmd_streamer: one instance without and one
// with the checksum, both driven with identical stimulus.
module tb_bluetooth_cmd_streamer;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        start;
  logic [3:0]  cmd;
  logic [31:0] din;
  logic        tx_ready;

  bluetooth_cmd_streamer_if #(.DATA_W(32)) bus0 ();
  bluetooth_cmd_streamer_if #(.DATA_W(32)) bus1 ();

  assign bus0.start          = start;
  assign bus0.command_select = cmd;
  assign bus0.input_data     = din;
  assign bus0.tx_ready       = tx_ready;
  assign bus1.start          = start;
  assign bus1.command_select = cmd;
  assign bus1.input_data     = din;
  assign bus1.tx_ready       = tx_ready;

  bluetooth_cmd_streamer #(.DATA_W(32), .CHECKSUM_EN(1'b0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0.master)
  );

  bluetooth_cmd_streamer #(.DATA_W(32), .CHECKSUM_EN(1'b1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.master)
  );

  always #5 clk = ~clk;

  int         vectors     = 0;
  int         miscompares = 0;
  logic [7:0] exp_q [2][$];
  int         done_cnt [2];
  bit         prev_stall [2];
  logic [7:0] prev_data [2];
  string      hex_str = "0123456789ABCDEF";

  // Single comparison point: counts and reports.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  function automatic logic [7:0] hex_ch(input logic [3:0] n);
    return hex_str[int'(n)];
  endfunction

  // Reference model: pushes the expected byte stream of both instances and
  // returns the packet length of the checksum-free instance.
  function automatic int expect_packet(input logic [3:0] c, input logic [31:0] d);
    logic [7:0] body[$];
    logic [7:0] x;
    case (c)
      4'h1:    body.push_back(8'h53);
      4'h2:    body.push_back(8'h57);
      4'h3:    body.push_back(8'h52);
      default: body.push_back(8'h51);
    endcase
    if (c == 4'h1 || c == 4'h2) begin
      for (int i = 7; i >= 0; i--) body.push_back(hex_ch(d[i*4 +: 4]));
    end else if (c == 4'h3) begin
      body.push_back(hex_ch(d[7:4]));
      body.push_back(hex_ch(d[3:0]));
    end
    x = 8'h00;
    foreach (body[i]) x ^= body[i];
    foreach (body[i]) begin
      exp_q[0].push_back(body[i]);
      exp_q[1].push_back(body[i]);
    end
    exp_q[0].push_back(8'h0D);
    exp_q[0].push_back(8'h0A);
    exp_q[1].push_back(hex_ch(x[7:4]));
    exp_q[1].push_back(hex_ch(x[3:0]));
    exp_q[1].push_back(8'h0D);
    exp_q[1].push_back(8'h0A);
    return body.size() + 2;
  endfunction

  // Per-instance stream monitor, sampled on the falling edge.
  task automatic monitor_step(input int k, input logic v, input logic r,
                              input logic [7:0] d, input logic dn, input logic rst_n);
    if (!rst_n) begin
      prev_stall[k] = 1'b0;
      return;
    end
    if (!v) checkOutput($sformatf("idle_data%0d", k), {24'h0, d}, 32'h0);
    if (prev_stall[k]) begin
      checkOutput($sformatf("hold_valid%0d", k), {31'h0, v}, 32'h1);
      checkOutput($sformatf("hold_data%0d", k), {24'h0, d}, {24'h0, prev_data[k]});
    end
    if (v && r) begin
      if (exp_q[k].size() == 0) checkOutput($sformatf("spurious_byte%0d", k), {31'h0, v}, 32'h0);
      else                      checkOutput($sformatf("byte%0d", k), {24'h0, d}, {24'h0, exp_q[k].pop_front()});
    end
    prev_stall[k] = v && !r;
    prev_data[k]  = d;
    if (dn) done_cnt[k]++;
  endtask

  always @(negedge clk) monitor_step(0, bus0.tx_valid, bus0.tx_ready, bus0.tx_data, bus0.done, reset);
  always @(negedge clk) monitor_step(1, bus1.tx_valid, bus1.tx_ready, bus1.tx_data, bus1.done, reset);

  // One-cycle start pulse; inputs are scrambled right after capture.
  task automatic applyStimulus(input logic [3:0] c, input logic [31:0] d);
    @(posedge clk); #1;
    start = 1'b1;
    cmd   = c;
    din   = d;
    @(posedge clk); #1;
    start = 1'b0;
    cmd   = 4'($urandom);
    din   = ~d;
  endtask

  task automatic run_packet(input logic [3:0] c, input logic [31:0] d,
                            input int stall_from, input int stall_len);
    int len0, len1, cyc, d0, d1;
    int done_at [2];
    len0 = expect_packet(c, d);
    len1 = len0 + 2;
    d0 = done_cnt[0];
    d1 = done_cnt[1];
    tx_ready = 1'b1;
    applyStimulus(c, d);
    cyc = 1;
    done_at[0] = 0;
    done_at[1] = 0;
    checkOutput("busy_after_start", {31'h0, bus0.busy}, 32'h1);
    checkOutput("hdr_valid", {31'h0, bus1.tx_valid}, 32'h1);
    while ((done_at[0] == 0 || done_at[1] == 0) && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
      tx_ready = !(stall_len > 0 && cyc >= stall_from && cyc < stall_from + stall_len);
      start    = (stall_len > 0 && cyc == stall_from + 1);
      if (start) begin
        cmd = 4'h4;
        din = $urandom;
      end
      if (bus0.done && done_at[0] == 0) begin
        done_at[0] = cyc;
        checkOutput("busy_in_done0", {31'h0, bus0.busy}, 32'h0);
      end
      if (bus1.done && done_at[1] == 0) begin
        done_at[1] = cyc;
        checkOutput("busy_in_done1", {31'h0, bus1.busy}, 32'h0);
      end
    end
    start    = 1'b0;
    tx_ready = 1'b1;
    checkOutput("done_cycle0", done_at[0], len0 + 1 + stall_len);
    checkOutput("done_cycle1", done_at[1], len1 + 1 + stall_len);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("done_pulses0", done_cnt[0] - d0, 1);
    checkOutput("done_pulses1", done_cnt[1] - d1, 1);
    checkOutput("left_over0", exp_q[0].size(), 0);
    checkOutput("left_over1", exp_q[1].size(), 0);
  endtask

  task automatic illegal_cmd(input logic [3:0] c);
    tx_ready = 1'b1;
    applyStimulus(c, 32'h12345678);
    checkOutput("err_pulse0", {31'h0, bus0.error}, 32'h1);
    checkOutput("err_pulse1", {31'h0, bus1.error}, 32'h1);
    checkOutput("err_busy", {31'h0, bus0.busy}, 32'h0);
    checkOutput("err_valid", {31'h0, bus1.tx_valid}, 32'h0);
    @(posedge clk); #1;
    checkOutput("err_clear", {31'h0, bus0.error}, 32'h0);
    checkOutput("err_busy_later", {31'h0, bus1.busy}, 32'h0);
    checkOutput("err_valid_later", {31'h0, bus0.tx_valid}, 32'h0);
  endtask

  task automatic reset_mid_packet();
    int len0, d0, d1;
    len0 = expect_packet(4'h1, 32'hCAFE0123);
    tx_ready = 1'b1;
    applyStimulus(4'h1, 32'hCAFE0123);
    repeat (4) @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    checkOutput("rst_valid0", {31'h0, bus0.tx_valid}, 32'h0);
    checkOutput("rst_valid1", {31'h0, bus1.tx_valid}, 32'h0);
    checkOutput("rst_busy", {31'h0, bus0.busy}, 32'h0);
    checkOutput("rst_done", {31'h0, bus1.done}, 32'h0);
    checkOutput("rst_data", {24'h0, bus0.tx_data}, 32'h0);
    checkOutput("rst_bytes_before", len0 - exp_q[0].size(), 4);
    exp_q[0].delete();
    exp_q[1].delete();
    d0 = done_cnt[0];
    d1 = done_cnt[1];
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("no_resume_busy", {31'h0, bus0.busy}, 32'h0);
    checkOutput("no_done0", done_cnt[0] - d0, 0);
    checkOutput("no_done1", done_cnt[1] - d1, 0);
    run_packet(4'h1, 32'h12345678, 0, 0);
  endtask

  initial begin
    int c, sf, sl;
    start    = 1'b0;
    cmd      = 4'h0;
    din      = 32'h0;
    tx_ready = 1'b1;
    #2 reset = 1'b0;
    #10;
    checkOutput("reset_valid0", {31'h0, bus0.tx_valid}, 32'h0);
    checkOutput("reset_valid1", {31'h0, bus1.tx_valid}, 32'h0);
    checkOutput("reset_busy", {31'h0, bus0.busy}, 32'h0);
    checkOutput("reset_done", {31'h0, bus1.done}, 32'h0);
    checkOutput("reset_error", {31'h0, bus0.error}, 32'h0);
    checkOutput("reset_data", {24'h0, bus1.tx_data}, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1;

    $display("[TB] directed packets");
    run_packet(4'h1, 32'h12345678, 0, 0);
    run_packet(4'h3, 32'h000000AB, 0, 0);
    run_packet(4'h4, 32'h00000000, 0, 0);
    run_packet(4'h2, 32'h9ABCDEF0, 0, 0);

    $display("[TB] illegal commands");
    illegal_cmd(4'h0);
    illegal_cmd(4'hF);

    $display("[TB] backpressure with ignored start");
    run_packet(4'h1, 32'h12345678, 4, 3);

    $display("[TB] reset mid-packet");
    reset_mid_packet();

    $display("[TB] random packets");
    for (int n = 0; n < 8; n++) begin
      c  = $urandom_range(1, 4);
      sf = $urandom_range(2, 3);
      sl = $urandom_range(0, 3);
      run_packet(4'(c), $urandom, sf, sl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bluetooth_cmd_streamer.md
BLUETOOTH_CMD_STREAMER -- requirements
Module: bluetooth_cmd_streamer

Interface
REQ-001 SHALL have parameter DATA_W, default 32, payload width in bits; legal values are multiples of 4, from 8 to 64.
REQ-002 SHALL have parameter CHECKSUM_EN, default 0; when 1, a two-character hex XOR checksum is inserted before the terminator.
REQ-003 SHALL have port clk, input, 1, sole clock; all state changes occur on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port input_data, input, DATA_W, command payload; sampled at start.
REQ-006 SHALL have port command_select, input, 4, command code; sampled at start.
REQ-007 SHALL have port start, input, 1, request to encode; honoured only in IDLE.
REQ-008 SHALL have port tx_data, output, 8, current ASCII byte.
REQ-009 SHALL have port tx_valid, output, 1, tx_data valid.
REQ-010 SHALL have port tx_ready, input, 1, downstream accepts the byte.
REQ-011 SHALL have port busy, output, 1, high from the cycle after start is accepted until done.
REQ-012 SHALL have port done, output, 1, one-cycle pulse when a packet completes.
REQ-013 SHALL have port error, output, 1, one-cycle pulse on an illegal command.

Function
REQ-014 SHALL use packet format: header byte, hex payload, optional checksum, 0x0D, 0x0A.
REQ-015 SHALL map command codes as follows:
- 4'h1 SEND: header 'S' (0x53); payload is all DATA_W/4 nibbles.
- 4'h2 WRITE: header 'W' (0x57); payload is all DATA_W/4 nibbles.
- 4'h3 READ: header 'R' (0x52); payload is input_data[7:0] only, 2 chars.
- 4'h4 STATUS: header 'Q' (0x51); no payload.
REQ-016 SHALL treat any other command code as illegal: error pulses for one cycle the cycle after start, no tx_valid is asserted, and the block stays in IDLE.
REQ-017 SHALL encode payload nibbles most-significant first as uppercase ASCII: 0-9 -> 0x30-0x39, A-F -> 0x41-0x46.
REQ-018 SHALL use state machine IDLE -> HDR -> PAYLOAD -> CKSUM -> CR -> LF -> DONE -> IDLE, with these transitions:
- PAYLOAD is skipped for STATUS.
- CKSUM is skipped when CHECKSUM_EN=0.
- DONE lasts exactly one cycle, with done=1 and busy=0.
REQ-019 SHALL, when start=1 in IDLE with a legal command, latch input_data and command_select and present the header on tx_data with tx_valid=1 on the next cycle.
REQ-020 SHALL count a byte as transferred on a rising edge with tx_valid and tx_ready both 1; the next byte appears on the following cycle, giving one byte per cycle under continuous tx_ready.
REQ-021 SHALL hold tx_data stable and tx_valid high while tx_ready=0; tx_valid SHALL NOT drop before the transfer.
REQ-022 SHALL ignore start while busy; changes to input_data and command_select during a packet SHALL NOT affect it.
REQ-023 SHALL compute the checksum as the 8-bit XOR of all preceding packet bytes (header and payload characters), sent as two uppercase hex chars, high nibble first.
REQ-024 SHALL pulse done on the cycle after the 0x0A transfer; start is accepted again in the IDLE cycle after DONE.
REQ-025 SHALL drive tx_data=0x00 whenever tx_valid=0.

Reset
REQ-026 SHALL, while reset=0, force the state to IDLE and tx_data=0x00, tx_valid=0, busy=0, done=0, error=0, and clear all latched data, independent of clk.
REQ-027 SHALL abort any packet in progress on reset assertion, with no done pulse, and not resume it after release.
REQ-028 SHALL accept start no earlier than the first rising edge after reset deasserts.

Verification
REQ-029 SHALL verify SEND (DATA_W=32, CHECKSUM_EN=0, tx_ready=1, input_data=32'h12345678, cmd 4'h1): stream 53 31 32 33 34 35 36 37 38 0D 0A in 11 consecutive cycles, then a single done pulse.
REQ-030 SHALL verify READ (input_data=32'h000000AB, cmd 4'h3): stream 52 41 42 0D 0A.
REQ-031 SHALL verify STATUS with CHECKSUM_EN=1 (cmd 4'h4): stream 51 35 31 0D 0A.
REQ-032 SHALL verify an illegal command (cmd 4'h0 or 4'hF with start): one error pulse, tx_valid never asserts, busy stays 0.
REQ-033 SHALL verify backpressure: tx_ready=0 for 3 cycles at payload byte 0x33 holds tx_data=0x33 and tx_valid=1, and the stream resumes with no lost or duplicated bytes; a start pulse mid-packet is ignored.
REQ-034 SHALL verify reset mid-packet: reset=0 after 4 bytes immediately drops tx_valid and busy with no done; a new SEND after release emits the full packet from 0x53.
